// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline and its sequencing controller.
// The pipeline drives hazard observations; the controller returns enables, flushes and counters.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_rs;
  logic [2:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_dump;
  logic             ex_load;
  logic             ex_regwrite;
  logic [2:0]       ex_dst;
  logic             ex_redirect;
  logic             imem_stall;
  logic             dmem_stall;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dump,
           ex_load, ex_regwrite, ex_dst, ex_redirect, imem_stall, dmem_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_dump,
           ex_load, ex_regwrite, ex_dst, ex_redirect, imem_stall, dmem_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, redirects, memory stalls and halt/drain,
// plus saturating stall/redirect counters. Enables and flushes are combinational (zero latency).
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_drain;
  logic [DW-1:0]    w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lu;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [4:0]       w_en;     // {pc, ifid, idex, exmem, memwb}
  logic [1:0]       w_flush;  // {ifid, idex}
  logic             w_halted;

  assign w_lu = bus.id_valid & bus.ex_load & bus.ex_regwrite &
                ((bus.id_rs_used & (bus.id_rs == bus.ex_dst)) |
                 (bus.id_rt_used & (bus.id_rt == bus.ex_dst)));

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_en        = '1;
    w_flush     = '0;
    w_halted    = 1'b0;
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;

    // While reset is held the pipeline registers clear in parallel, so leave everything enabled.
    if (rst) begin
      unique case (r_state)
        S_RUN: begin
          if (bus.dmem_stall) begin
            w_en        = '0;
            w_stall_inc = 1'b1;
          end else if (bus.ex_redirect) begin
            w_flush     = 2'b11;
            w_flush_inc = 1'b1;
          end else if (w_lu) begin
            w_en[4:3]   = 2'b00;
            w_flush[0]  = 1'b1;
            w_stall_inc = 1'b1;
          end else if (bus.imem_stall) begin
            w_en[4]     = 1'b0;
            w_flush[1]  = 1'b1;
            w_stall_inc = 1'b1;
          end else if (bus.id_valid && bus.id_dump) begin
            w_en[4]     = 1'b0;
            w_flush[1]  = 1'b1;
            w_state_nxt = S_DRAIN;
            w_drain_nxt = '0;
          end
        end
        S_DRAIN: begin
          w_en[4]    = 1'b0;
          w_flush[1] = 1'b1;
          if (bus.dmem_stall) begin
            w_en = '0;
          end else begin
            w_drain_nxt = r_drain + DW'(1);
            if (w_drain_nxt == DW'(DRAIN_CYCLES)) w_state_nxt = S_HALTED;
          end
        end
        S_HALTED: begin
          w_en     = '0;
          w_halted = 1'b1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (!rst) begin
      r_state     <= S_RUN;
      r_drain     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      if (w_stall_inc && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en      = w_en[4];
  assign bus.ifid_en    = w_en[3];
  assign bus.idex_en    = w_en[2];
  assign bus.exmem_en   = w_en[1];
  assign bus.memwb_en   = w_en[0];
  assign bus.ifid_flush = w_flush[1];
  assign bus.idex_flush = w_flush[0];
  assign bus.halted     = w_halted;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.flush_cnt  = r_flush_cnt;
endmodule
